// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing generator (640x480@60 by default) running from the
//   100 MHz board clock. A down-divided pixel enable (p_tick) advances the
//   horizontal/vertical counters. hsync, vsync and video_on are registered and
//   always describe the current x/y with no added latency.
//
// Ports
//   clk_100MHz  in   system clock
//   reset       in   asynchronous, active-high reset
//   p_tick      out  one-clock pixel enable, once every DIV clocks
//   x, y        out  current horizontal / vertical count
//   video_on    out  1 while (x,y) is inside the visible area
//   hsync       out  horizontal sync, active level SYNC_POL
//   vsync       out  vertical sync, active level SYNC_POL
//   line_end    out  one-clock pulse on the last pixel of a line
//   frame_end   out  one-clock pulse on the last pixel of a frame
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int   DIV       = 4,
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DW-1:0] r_div;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;

  logic          w_tick;
  logic          w_x_last;
  logic          w_y_last;
  logic [9:0]    w_x_next;
  logic [9:0]    w_y_next;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_vid;

  // Pixel divider: the tick is decoded from the registered count only, so it
  // carries no combinational hazard from upstream logic.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick   = (r_div == DIV_LAST);
  assign w_x_last = (r_x == H_LAST);
  assign w_y_last = (r_y == V_LAST);
  assign w_x_next = w_x_last ? 10'd0 : r_x + 10'd1;
  assign w_y_next = w_x_last ? (w_y_last ? 10'd0 : r_y + 10'd1) : r_y;

  // Syncs and blanking are decoded from the *next* position and registered on
  // the same edge as x/y, so they line up with the counters with no lag.
  assign w_hs_act = (w_x_next >= HS_START) && (w_x_next < HS_END);
  assign w_vs_act = (w_y_next >= VS_START) && (w_y_next < VS_END);
  assign w_vid    = (w_x_next < H_VIS) && (w_y_next < V_VIS);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b1;
    end else if (w_tick) begin
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_hsync    <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_vid;
    end
  end

  assign p_tick    = w_tick;
  assign x         = r_x;
  assign y         = r_y;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign video_on  = r_video_on;
  assign line_end  = w_tick && w_x_last;
  assign frame_end = w_tick && w_x_last && w_y_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d, rst_s;
  logic       d_pt, d_vo, d_hs, d_vs, d_le, d_fe;
  logic [9:0] d_x, d_y;
  logic       s_pt, s_vo, s_hs, s_vs, s_le, s_fe;
  logic [9:0] s_x, s_y;

  // Full-size 640x480 timing.
  vga_sync_gen dut_d (
    .clk_100MHz(clk), .reset(rst_d), .p_tick(d_pt), .x(d_x), .y(d_y),
    .video_on(d_vo), .hsync(d_hs), .vsync(d_vs), .line_end(d_le), .frame_end(d_fe)
  );

  // Miniature timing: H_TOTAL=14, V_TOTAL=7, frame = 14*7*2 = 196 clocks.
  vga_sync_gen #(
    .DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_s (
    .clk_100MHz(clk), .reset(rst_s), .p_tick(s_pt), .x(s_x), .y(s_y),
    .video_on(s_vo), .hsync(s_hs), .vsync(s_vs), .line_end(s_le), .frame_end(s_fe)
  );

  typedef struct {
    int   k;     // index of the p_tick (0 = first tick after reset release)
    int   x;
    int   y;
    logic hs, vs, vo, le, fe;
  } exp_t;

  exp_t q_d[$];
  exp_t q_s[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit done_s = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_d(input int k, input int x, input int y,
                        input logic hs, input logic vs, input logic vo,
                        input logic le, input logic fe);
    exp_t e;
    e.k = k; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.vo = vo; e.le = le; e.fe = fe;
    q_d.push_back(e);
  endtask

  task automatic push_s(input int k, input int x, input int y,
                        input logic hs, input logic vs, input logic vo,
                        input logic le, input logic fe);
    exp_t e;
    e.k = k; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.vo = vo; e.le = le; e.fe = fe;
    q_s.push_back(e);
  endtask

  // Monitors: count p_ticks since reset release; when a tick index matches the
  // head of the queue, pop it and compare every output.
  initial begin : mon_d
    int   k;
    exp_t e;
    k = 0;
    forever begin
      @(negedge clk);
      if (rst_d) begin
        k = 0;
      end else if (d_pt) begin
        if (q_d.size() > 0 && q_d[0].k == k) begin
          e = q_d.pop_front();
          chk($sformatf("d k=%0d x", k), 32'(d_x), 32'(e.x));
          chk($sformatf("d k=%0d y", k), 32'(d_y), 32'(e.y));
          chk($sformatf("d k=%0d hsync", k), 32'(d_hs), 32'(e.hs));
          chk($sformatf("d k=%0d vsync", k), 32'(d_vs), 32'(e.vs));
          chk($sformatf("d k=%0d video_on", k), 32'(d_vo), 32'(e.vo));
          chk($sformatf("d k=%0d line_end", k), 32'(d_le), 32'(e.le));
          chk($sformatf("d k=%0d frame_end", k), 32'(d_fe), 32'(e.fe));
        end
        k++;
      end
    end
  end

  initial begin : mon_s
    int   k;
    exp_t e;
    k = 0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        k = 0;
      end else if (s_pt) begin
        if (q_s.size() > 0 && q_s[0].k == k) begin
          e = q_s.pop_front();
          chk($sformatf("s k=%0d x", k), 32'(s_x), 32'(e.x));
          chk($sformatf("s k=%0d y", k), 32'(s_y), 32'(e.y));
          chk($sformatf("s k=%0d hsync", k), 32'(s_hs), 32'(e.hs));
          chk($sformatf("s k=%0d vsync", k), 32'(s_vs), 32'(e.vs));
          chk($sformatf("s k=%0d video_on", k), 32'(s_vo), 32'(e.vo));
          chk($sformatf("s k=%0d line_end", k), 32'(s_le), 32'(e.le));
          chk($sformatf("s k=%0d frame_end", k), 32'(s_fe), 32'(e.fe));
        end
        k++;
      end
    end
  end

  // Miniature instance: frame period, line_end count and vsync width per frame.
  initial begin : frame_s
    int cyc, last_fe, frames, n_le, n_vs_low;
    cyc = 0; last_fe = -1; frames = 0; n_le = 0; n_vs_low = 0;
    wait (rst_s === 1'b1);
    wait (rst_s === 1'b0);
    while (frames < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (last_fe >= 0) begin
        if (s_le) n_le++;
        if (!s_vs) n_vs_low++;
      end
      if (s_fe) begin
        if (last_fe >= 0) begin
          chk($sformatf("s frame_end period #%0d", frames), 32'(cyc - last_fe), 32'd196);
          chk($sformatf("s line_end per frame #%0d", frames), 32'(n_le), 32'd7);
          chk($sformatf("s vsync low clks #%0d", frames), 32'(n_vs_low), 32'd28);
          frames++;
        end
        last_fe  = cyc;
        n_le     = 0;
        n_vs_low = 0;
      end
    end
    chk("s frames seen", 32'(frames), 32'd3);
    done_s = 1;
  end

  task automatic check_reset_d(input string tag);
    chk({tag, " x"}, 32'(d_x), 32'd0);
    chk({tag, " y"}, 32'(d_y), 32'd0);
    chk({tag, " hsync"}, 32'(d_hs), 32'd1);
    chk({tag, " vsync"}, 32'(d_vs), 32'd1);
    chk({tag, " video_on"}, 32'(d_vo), 32'd1);
    chk({tag, " p_tick"}, 32'(d_pt), 32'd0);
    chk({tag, " line_end"}, 32'(d_le), 32'd0);
    chk({tag, " frame_end"}, 32'(d_fe), 32'd0);
  endtask

  // Release reset on a negedge, then record after which rising edge p_tick is
  // first seen. With DIV=4 it rises after the 3rd edge (during the 4th clock).
  task automatic first_ticks_d(input string tag);
    int t[3];
    int n;
    n = 0;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      @(negedge clk);
      if (d_pt) begin
        t[n] = c;
        n++;
      end
    end
    chk({tag, " tick count"}, 32'(n), 32'd3);
    chk({tag, " first tick"}, 32'(t[0]), 32'd3);
    chk({tag, " second tick"}, 32'(t[1]), 32'd7);
    chk({tag, " third tick"}, 32'(t[2]), 32'd11);
  endtask

  initial begin : stim
    int   cnt_hs, cnt_vo, guard, s_first;
    bit   seen;

    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_d("reset");
    chk("s reset x", 32'(s_x), 32'd0);
    chk("s reset hsync", 32'(s_hs), 32'd1);
    chk("s reset p_tick", 32'(s_pt), 32'd0);

    // 640x480: horizontal landmarks plus the wrap into line 1.
    push_d(0,    0,   0, 1, 1, 1, 0, 0);
    push_d(639,  639, 0, 1, 1, 1, 0, 0);
    push_d(640,  640, 0, 1, 1, 0, 0, 0);
    push_d(655,  655, 0, 1, 1, 0, 0, 0);
    push_d(656,  656, 0, 0, 1, 0, 0, 0);
    push_d(751,  751, 0, 0, 1, 0, 0, 0);
    push_d(752,  752, 0, 1, 1, 0, 0, 0);
    push_d(799,  799, 0, 1, 1, 0, 1, 0);
    push_d(800,  0,   1, 1, 1, 1, 0, 0);
    push_d(1500, 700, 1, 0, 1, 0, 0, 0);

    // Miniature: hsync x=10..11, vsync y=5, visible x<8 && y<4.
    push_s(0,   0,  0, 1, 1, 1, 0, 0);
    push_s(7,   7,  0, 1, 1, 1, 0, 0);
    push_s(8,   8,  0, 1, 1, 0, 0, 0);
    push_s(9,   9,  0, 1, 1, 0, 0, 0);
    push_s(10,  10, 0, 0, 1, 0, 0, 0);
    push_s(11,  11, 0, 0, 1, 0, 0, 0);
    push_s(12,  12, 0, 1, 1, 0, 0, 0);
    push_s(13,  13, 0, 1, 1, 0, 1, 0);
    push_s(14,  0,  1, 1, 1, 1, 0, 0);
    push_s(55,  13, 3, 1, 1, 0, 1, 0);
    push_s(56,  0,  4, 1, 1, 0, 0, 0);
    push_s(70,  0,  5, 1, 0, 0, 0, 0);
    push_s(83,  13, 5, 1, 0, 0, 1, 0);
    push_s(84,  0,  6, 1, 1, 0, 0, 0);
    push_s(97,  13, 6, 1, 1, 0, 1, 1);
    push_s(98,  0,  0, 1, 1, 1, 0, 0);
    push_s(195, 13, 6, 1, 1, 0, 1, 1);

    rst_d = 1'b0;
    rst_s = 1'b0;
    fork
      first_ticks_d("d release");
      begin
        s_first = 0;
        for (int c = 1; c <= 10 && s_first == 0; c++) begin
          @(negedge clk);
          if (s_pt) s_first = c;
        end
        chk("s first tick", 32'(s_first), 32'd1);
      end
    join

    // Full line y=1: hsync low clocks and visible pixel count.
    cnt_hs = 0; cnt_vo = 0; seen = 0; guard = 0;
    while (!seen && guard < 8000) begin
      @(negedge clk);
      guard++;
      if (d_y == 10'd1) begin
        if (!d_hs) cnt_hs++;
        if (d_pt && d_vo) cnt_vo++;
        if (d_le) seen = 1;
      end
    end
    chk("d line1 end seen", 32'(seen), 32'd1);
    chk("d line1 hsync low clks", 32'(cnt_hs), 32'd384);
    chk("d line1 video_on ticks", 32'(cnt_vo), 32'd640);

    // Mid-line reset while hsync is active.
    guard = 0;
    while (!(d_x == 10'd700 && d_pt) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("d reached x=700", 32'(guard < 5000), 32'd1);
    chk("d hsync before reset", 32'(d_hs), 32'd0);
    chk("d queue drained before reset", 32'(q_d.size()), 32'd0);
    #1 rst_d = 1'b1;
    #1 check_reset_d("async reset");
    repeat (2) @(negedge clk);
    check_reset_d("held reset");

    push_d(0,   0,   0, 1, 1, 1, 0, 0);
    push_d(656, 656, 0, 0, 1, 0, 0, 0);
    push_d(799, 799, 0, 1, 1, 0, 1, 0);
    push_d(800, 0,   1, 1, 1, 1, 0, 0);
    rst_d = 1'b0;
    first_ticks_d("d re-release");

    guard = 0;
    while (q_d.size() > 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("d queue drained", 32'(q_d.size()), 32'd0);

    guard = 0;
    while (!done_s && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("s frame checker done", 32'(done_s), 32'd1);
    chk("s queue drained", 32'(q_s.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
